// File: rtl/esm_pkg.sv
// Shared ESM types and constants: selection modes, selector states, PRNG defaults.
package esm_pkg;

  typedef enum logic [1:0] {
    SEL_RAND    = 2'd0,
    SEL_RAND_NR = 2'd1,
    SEL_RR      = 2'd2
  } sel_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    READY = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS_DEF = 16'hB400;

  // Raw mode codes 2 and 3 both mean round-robin.
  function automatic sel_mode_e decode_mode(input logic [1:0] m);
    sel_mode_e r;
    case (m)
      2'd0:    r = SEL_RAND;
      2'd1:    r = SEL_RAND_NR;
      default: r = SEL_RR;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cand_map_selector_if.sv
// Load and select handshake bundle between candidate generator, selector and read port.
interface cand_map_selector_if #(
  parameter int BS = 16
) ();
  localparam int IW = $clog2(BS);
  localparam int CW = $clog2(BS + 1);

  logic          load_valid;
  logic          load_ready;
  logic [BS-1:0] cand_list;
  logic [1:0]    mode;
  logic          sel_req;
  logic          sel_valid;
  logic [IW-1:0] sel_index;
  logic          sel_last;
  logic [CW-1:0] count;
  logic          empty;
  logic          busy;

  modport master (
    output load_valid, cand_list, mode, sel_req,
    input  load_ready, sel_valid, sel_index, sel_last, count, empty, busy
  );

  modport slave (
    input  load_valid, cand_list, mode, sel_req,
    output load_ready, sel_valid, sel_index, sel_last, count, empty, busy
  );
endinterface

// File: rtl/esm_lfsr.sv
// Free-running Galois LFSR (right-shifting); shared PRNG for ESM blocks.
module esm_lfsr #(
  parameter int               W    = 16,
  parameter logic [W-1:0]     SEED = W'(16'hACE1),
  parameter logic [W-1:0]     TAPS = W'(16'hB400)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] state_o
);

  logic [W-1:0] state_q;

  // Shift right, folding the taps in whenever a one falls out of bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
    end else if (en_i) begin
      state_q <= (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/cand_map_selector.sv
// Compacts a candidate bitmap into an index table and hands out one index per request.
module cand_map_selector
  import esm_pkg::*;
#(
  parameter int                BS        = 16,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(LFSR_SEED_DEF)
) (
  input logic               clk,
  input logic               rst,
  cand_map_selector_if.slave sel_if
);

  localparam int IW = $clog2(BS);
  localparam int CW = $clog2(BS + 1);
  localparam int PW = LFSR_W + CW;

  state_e        state_q, state_d;
  sel_mode_e     mode_q;
  logic [BS-1:0] cand_q;
  logic [IW-1:0] scan_q;
  logic [IW-1:0] rr_ptr_q;
  logic [CW-1:0] count_q;
  logic [IW-1:0] table_q [BS];
  logic          sel_valid_q;
  logic          sel_last_q;
  logic [IW-1:0] sel_index_q;

  logic [LFSR_W-1:0] lfsr;
  logic              load_acc, sel_acc, scan_hit, scan_done, rr_wrap;
  logic              last_pick;
  logic [PW-1:0]     prod;
  logic [IW-1:0]     k_idx, last_idx, pick_idx;

  esm_lfsr #(
    .W    (LFSR_W),
    .SEED (LFSR_SEED),
    .TAPS (LFSR_W'(LFSR_TAPS_DEF))
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .en_i    (1'b1),
    .state_o (lfsr)
  );

  // Load wins over a same-cycle request; requests only count once a table exists.
  assign load_acc  = sel_if.load_valid && (state_q != SCAN);
  assign sel_acc   = sel_if.sel_req && (state_q == READY) && !load_acc;
  assign scan_hit  = cand_q[scan_q];
  assign scan_done = (scan_q == IW'(BS - 1));

  // Scaled pick: upper bits of r*count lie in [0, count) without a divider.
  assign prod     = PW'(lfsr) * PW'(count_q);
  assign k_idx    = IW'(prod >> LFSR_W);
  assign last_idx = IW'(count_q - CW'(1));
  assign rr_wrap  = (rr_ptr_q == last_idx);

  // Choose the returned entry and whether it closes out the table or the RR lap.
  always_comb begin
    pick_idx  = table_q[k_idx];
    last_pick = 1'b0;
    if (mode_q == SEL_RR) begin
      pick_idx  = table_q[rr_ptr_q];
      last_pick = rr_wrap;
    end else if (mode_q == SEL_RAND_NR) begin
      last_pick = (count_q == CW'(1));
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load_acc) state_d = SCAN;
      SCAN:    if (scan_done) state_d = (scan_hit || (count_q != '0)) ? READY : IDLE;
      READY: begin
        if (load_acc) state_d = SCAN;
        else if (sel_acc && (mode_q == SEL_RAND_NR) && (count_q == CW'(1))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Table build, pick, removal and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= SEL_RAND;
      cand_q      <= '0;
      scan_q      <= '0;
      rr_ptr_q    <= '0;
      count_q     <= '0;
      sel_valid_q <= 1'b0;
      sel_last_q  <= 1'b0;
      sel_index_q <= '0;
      for (int i = 0; i < BS; i++) table_q[i] <= '0;
    end else begin
      sel_valid_q <= sel_acc;
      sel_last_q  <= sel_acc && last_pick;
      if (sel_acc) sel_index_q <= pick_idx;

      if (load_acc) begin
        cand_q   <= sel_if.cand_list;
        mode_q   <= decode_mode(sel_if.mode);
        count_q  <= '0;
        rr_ptr_q <= '0;
        scan_q   <= '0;
      end else if (state_q == SCAN) begin
        scan_q <= scan_q + IW'(1);
        if (scan_hit) begin
          table_q[IW'(count_q)] <= scan_q;
          count_q               <= count_q + CW'(1);
        end
      end else if (sel_acc) begin
        if (mode_q == SEL_RAND_NR) begin
          table_q[k_idx] <= table_q[last_idx];
          count_q        <= count_q - CW'(1);
        end else if (mode_q == SEL_RR) begin
          rr_ptr_q <= rr_wrap ? '0 : rr_ptr_q + IW'(1);
        end
      end
    end
  end

  assign sel_if.load_ready = (state_q != SCAN);
  assign sel_if.busy       = (state_q == SCAN);
  assign sel_if.count      = count_q;
  assign sel_if.empty      = (count_q == '0);
  assign sel_if.sel_valid  = sel_valid_q;
  assign sel_if.sel_index  = sel_index_q;
  assign sel_if.sel_last   = sel_last_q;

endmodule

// File: tb/tb_cand_map_selector.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_cand_map_selector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cand_map_selector_if #(.BS(16)) bus ();

  cand_map_selector #(.BS(16), .LFSR_W(16), .LFSR_SEED(16'hACE1)) dut (
    .clk    (clk),
    .rst    (rst),
    .sel_if (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Model state: 0 idle, 1 scanning, 2 table ready.
  int        m_st, m_cnt, m_rr, m_scan, m_mode;
  int        m_tbl [16];
  bit [15:0] m_cand;
  bit [15:0] m_lfsr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit [15:0] lfsr_next(input bit [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic m_reset();
    m_st = 0; m_cnt = 0; m_rr = 0; m_scan = 0; m_mode = 0;
    m_cand = '0;
    m_lfsr = 16'hACE1;
    for (int i = 0; i < 16; i++) m_tbl[i] = 0;
  endtask

  task automatic drive(input bit lv, input bit [15:0] cl, input bit [1:0] md, input bit sr);
    bus.load_valid = lv;
    bus.cand_list  = cl;
    bus.mode       = md;
    bus.sel_req    = sr;
  endtask

  task automatic check_static();
    chk("count", 32'(bus.count), 32'(m_cnt));
    chk("empty", 32'(bus.empty), 32'(m_cnt == 0));
    chk("busy", 32'(bus.busy), 32'(m_st == 1));
    chk("load_ready", 32'(bus.load_ready), 32'(m_st != 1));
  endtask

  // One clock: advance the model with the driven inputs, then compare after the edge.
  task automatic tick();
    bit ev, el;
    int ei, k;
    ev = 0; el = 0; ei = 0;
    if (bus.load_valid && m_st != 1) begin
      m_cand = bus.cand_list; m_mode = int'(bus.mode);
      m_cnt = 0; m_rr = 0; m_scan = 0; m_st = 1;
    end else if (m_st == 1) begin
      if (m_cand[m_scan]) begin m_tbl[m_cnt] = m_scan; m_cnt++; end
      if (m_scan == 15) m_st = (m_cnt > 0) ? 2 : 0;
      m_scan++;
    end else if (m_st == 2 && bus.sel_req) begin
      ev = 1;
      if (m_mode >= 2) begin
        ei = m_tbl[m_rr];
        el = (m_rr == m_cnt - 1);
        m_rr = el ? 0 : m_rr + 1;
      end else begin
        k  = int'((longint'(m_lfsr) * longint'(m_cnt)) >> 16);
        ei = m_tbl[k];
        if (m_mode == 1) begin
          m_tbl[k] = m_tbl[m_cnt - 1];
          m_cnt--;
          el = (m_cnt == 0);
          if (m_cnt == 0) m_st = 0;
        end
      end
    end
    m_lfsr = lfsr_next(m_lfsr);
    @(posedge clk);
    #1;
    chk("sel_valid", 32'(bus.sel_valid), 32'(ev));
    if (ev) begin
      chk("sel_index", 32'(bus.sel_index), 32'(ei));
      chk("sel_last", 32'(bus.sel_last), 32'(el));
    end
    check_static();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int          hist [16];
  int          obs_idx [5];
  int          obs_last [5];
  int          nv;
  bit [15:0]   mask;
  int          exp_rr [5] = '{0, 5, 10, 15, 0};
  int          exp_rl [5] = '{0, 0, 0, 1, 0};

  initial begin
    drive(0, 16'h0, 2'd0, 0);
    m_reset();
    #12;
    chk("rst_sel_valid", 32'(bus.sel_valid), 32'd0);
    chk("rst_sel_index", 32'(bus.sel_index), 32'd0);
    chk("rst_sel_last", 32'(bus.sel_last), 32'd0);
    check_static();
    @(negedge clk);
    rst = 1'b0;

    // Empty bitmap: 16 busy cycles, then IDLE with nothing to select.
    drive(1, 16'h0000, 2'd0, 0);
    tick();
    drive(0, 16'h0, 2'd0, 0);
    ticks(16);
    chk("empty_after_scan", 32'(bus.empty), 32'd1);
    drive(0, 16'h0, 2'd0, 1);
    tick();
    chk("idle_no_valid", 32'(bus.sel_valid), 32'd0);

    // Round-robin over 0x8421.
    drive(1, 16'h8421, 2'd2, 0);
    tick();
    drive(0, 16'h0, 2'd0, 0);
    ticks(16);
    chk("rr_count", 32'(bus.count), 32'd4);
    drive(0, 16'h0, 2'd0, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      obs_idx[i]  = int'(bus.sel_index);
      obs_last[i] = int'(bus.sel_last);
    end
    for (int i = 0; i < 5; i++) begin
      chk("rr_seq_idx", 32'(obs_idx[i]), 32'(exp_rr[i]));
      chk("rr_seq_last", 32'(obs_last[i]), 32'(exp_rl[i]));
    end

    // Without replacement over 0x00F0: four distinct picks, then drained.
    drive(1, 16'h00F0, 2'd1, 0);
    tick();
    drive(0, 16'h0, 2'd0, 0);
    ticks(16);
    drive(0, 16'h0, 2'd1, 1);
    mask = '0; nv = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.sel_valid) begin
        nv++;
        mask[bus.sel_index] = 1'b1;
      end
    end
    chk("nr_perm", 32'(mask), 32'h00F0);
    chk("nr_nvalid", 32'(nv), 32'd4);
    chk("nr_empty", 32'(bus.empty), 32'd1);

    // Single candidate with replacement.
    drive(1, 16'h0001, 2'd0, 0);
    tick();
    drive(0, 16'h0, 2'd0, 0);
    ticks(16);
    drive(0, 16'h0, 2'd0, 1);
    ticks(100);

    // Full bitmap with replacement: distribution.
    drive(1, 16'hFFFF, 2'd0, 0);
    tick();
    drive(0, 16'h0, 2'd0, 0);
    ticks(16);
    for (int i = 0; i < 16; i++) hist[i] = 0;
    drive(0, 16'h0, 2'd0, 1);
    for (int i = 0; i < 4096; i++) begin
      tick();
      if (bus.sel_valid) hist[bus.sel_index]++;
    end
    for (int i = 0; i < 16; i++)
      chk("hist_bin", 32'(hist[i] >= 154 && hist[i] <= 358), 32'd1);

    // Load and request together in READY: load wins.
    drive(1, 16'h0300, 2'd0, 1);
    tick();
    chk("load_prio_no_valid", 32'(bus.sel_valid), 32'd0);
    drive(0, 16'h0, 2'd0, 0);
    ticks(16);
    chk("reload_count", 32'(bus.count), 32'd2);

    // Reset in the middle of a scan.
    drive(1, 16'hFFFF, 2'd0, 0);
    tick();
    drive(0, 16'h0, 2'd0, 0);
    ticks(7);
    #2 rst = 1'b1;
    #1;
    m_reset();
    chk("midscan_rst_count", 32'(bus.count), 32'd0);
    chk("midscan_rst_busy", 32'(bus.busy), 32'd0);
    chk("midscan_rst_empty", 32'(bus.empty), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 16'hFFFF, 2'd3, 0);
    tick();
    drive(0, 16'h0, 2'd0, 0);
    ticks(16);
    chk("after_rst_count", 32'(bus.count), 32'd16);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 24) == 0), 16'($urandom) & 16'($urandom),
            2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
